mat_reg_streamer: RTL and testbench
===================================

// Module: mat_reg_streamer
// PURPOSE
//  Read-side sequencer for a matrix register: streams N row/column/diagonal vectors out of the register.
//  Drives the register's read_op/read_param1/read_param2 and captures its combinational data_out.
//  Presents each vector on a valid/ready output port for the systolic array or store unit.
//  Started by the instruction decoder; reports busy/done so the decoder can serialize register traffic.
// PARAMETERS
//  WIDTH            128                 matrix dimension / vector length
//  WIDTH_ADDR_SIZE  $clog2(WIDTH)       index width
// PORTS
//  clock        in   1                  system clock
//  reset        in   1                  synchronous, active-high reset
//  start        in   1                  request pulse; sampled only in IDLE
//  mode         in   MatDataReadOp_t    ROW, COL or DIAG; anything else is rejected
//  start_index  in   WIDTH_ADDR_SIZE    first vector index
//  count        in   WIDTH_ADDR_SIZE+1  number of vectors to stream (0..2*WIDTH-1)
//  read_op      out  MatDataReadOp_t    to register read port
//  read_param1  out  WIDTH_ADDR_SIZE    current vector index
//  read_param2  out  WIDTH_ADDR_SIZE    tied 0
//  reg_data     in   real[WIDTH]        register data_out
//  out_data     out  real[WIDTH]        captured vector
//  out_index    out  WIDTH_ADDR_SIZE    index of out_data
//  out_last     out  1                  out_data is final vector of the request
//  out_valid    out  1                  out_data valid
//  out_ready    in   1                  consumer accepts out_data
//  busy         out  1                  state != IDLE
//  done         out  1                  one-cycle pulse on completion
//  start_err    out  1                  one-cycle pulse: start with illegal mode
// BEHAVIOUR
//  One clock; reset is synchronous and active-high.
//  Reset: state=IDLE; out_valid, out_last, busy, done, start_err=0; out_index=0; out_data all 0.0.
//   Reset has priority in every state; mid-stream reset abandons the request with no done pulse.
//  FSM with two states: IDLE and STREAM. Registers: idx, rem (remaining count), lmode.
//  IDLE:
//   - start && mode in {ROW,COL,DIAG}: lmode<=mode, idx<=start_index, rem<=count, go STREAM.
//   - start && other mode: start_err<=1 for one cycle; stay IDLE.
//   - read_op=DISABLE, read_param1=0.
//  STREAM:
//   - read_op = (rem!=0) ? lmode : DISABLE; read_param1=idx (combinational from registers).
//   - load = rem!=0 && (!out_valid || out_ready).
//   - On load: out_data<=reg_data; out_index<=idx; out_last<=(rem==1); out_valid<=1.
//     Also: idx<=idx+1 (wraps mod WIDTH); rem<=rem-1.
//   - Else if out_ready: out_valid<=0.
//   - rem==0 && (!out_valid || out_ready): done<=1, out_valid<=0, out_last<=0, go IDLE.
//   - start is ignored while in STREAM (no error).
//  Handshake:
//   - Transfer occurs when out_valid && out_ready.
//   - out_data, out_index and out_last are stable while out_valid && !out_ready.
//   - Stall holds idx, so read_param1 is held as well.
//  Timing: start sampled at cycle 0; first capture at end of cycle 1; out_valid rises in cycle 2.
//   - With out_ready held high, one vector per cycle.
//   - done and IDLE both occur in cycle N+2; a new start is accepted in that same cycle.
//   - count=0: enters STREAM, no vectors; done in cycle 2.
//  Data is sampled from the register at the capture cycle. The decoder holds the register write_op at DISABLE
//   while busy for a consistent snapshot; the streamer does not enforce this.
//  DIAG index k reads mem[i][k-i] for i<=k, else mem[i][WIDTH+k-i].
// TESTING (WIDTH=4, mem[r][c]=10r+c, out_ready=1 unless stated)
//  ROW, start_index=0, count=4: rows [0,1,2,3]..[30..33]; out_index 0..3; out_last on 4th; done cycle 6.
//  COL, start_index=3, count=2: [3,13,23,33] then [0,10,20,30] (wrap); out_last on 2nd.
//  ROW, count=3, out_ready low cycles 2-4: first vector held stable; read_param1 holds 1; all 3 delivered; done cycle 8.
//  DIAG, start_index=1, count=1: out_data=[1,10,23,32].
//  mode=SCALAR: start_err pulse in cycle 1, busy stays 0. count=0: done in cycle 2, no out_valid.
//  Start during STREAM: ignored.
//  reset after 2 transfers of count=4: next cycle out_valid=0, busy=0, read_op=DISABLE, no done; new start streams normally.

Source files
------------

// File: rtl/mat_reg_streamer.sv
// Matrix register read sequencer: streams row/column/diagonal vectors out of the register.
// Latency: first vector valid two cycles after start; one vector per cycle with out_ready high.
// Backpressure: out_ready low holds out_data/out_index/out_last and the read index until accepted.

package mat_reg_pkg;
  typedef enum logic [2:0] {
    DISABLE = 3'd0,
    ROW     = 3'd1,
    COL     = 3'd2,
    DIAG    = 3'd3,
    SCALAR  = 3'd4
  } MatDataReadOp_t;
endpackage

module mat_reg_streamer
  import mat_reg_pkg::*;
#(
  parameter int WIDTH           = 128,
  parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH),
  // Element bit pattern (e.g. FP32) carried untouched from register to consumer.
  parameter int DATA_W          = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  MatDataReadOp_t                    mode,
  input  logic [WIDTH_ADDR_SIZE-1:0]        start_index,
  input  logic [WIDTH_ADDR_SIZE:0]          count,
  output MatDataReadOp_t                    read_op,
  output logic [WIDTH_ADDR_SIZE-1:0]        read_param1,
  output logic [WIDTH_ADDR_SIZE-1:0]        read_param2,
  input  logic [WIDTH-1:0][DATA_W-1:0]      reg_data,
  output logic [WIDTH-1:0][DATA_W-1:0]      out_data,
  output logic [WIDTH_ADDR_SIZE-1:0]        out_index,
  output logic                              out_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              done,
  output logic                              start_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [WIDTH_ADDR_SIZE:0]   REM_ONE  = 1;
  localparam logic [WIDTH_ADDR_SIZE-1:0] IDX_ONE  = 1;
  localparam logic [WIDTH_ADDR_SIZE-1:0] IDX_LAST = WIDTH_ADDR_SIZE'(WIDTH - 1);

  state_t                     state_q, state_d;
  MatDataReadOp_t             lmode_q;
  logic [WIDTH_ADDR_SIZE-1:0] idx_q;
  logic [WIDTH_ADDR_SIZE:0]   rem_q;

  logic mode_legal;
  logic accept;
  logic load;
  logic finish;

  assign mode_legal  = (mode == ROW) || (mode == COL) || (mode == DIAG);
  assign accept      = (state_q == IDLE) && start && mode_legal;
  assign busy        = (state_q != IDLE);
  assign read_param2 = '0;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: leave IDLE on a legal start, return once the last vector has drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = STREAM;
      STREAM:  if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register read port drive plus the capture/finish strobes for the datapath.
  always_comb begin
    read_op     = DISABLE;
    read_param1 = '0;
    load        = 1'b0;
    finish      = 1'b0;
    if (state_q == STREAM) begin
      read_op     = (rem_q != '0) ? lmode_q : DISABLE;
      read_param1 = idx_q;
      load        = (rem_q != '0) && (!out_valid || out_ready);
      finish      = (rem_q == '0) && (!out_valid || out_ready);
    end
  end

  // Request bookkeeping, output capture and status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      lmode_q   <= DISABLE;
      idx_q     <= '0;
      rem_q     <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      done      <= finish;
      start_err <= (state_q == IDLE) && start && !mode_legal;

      if (accept) begin
        lmode_q <= mode;
        idx_q   <= start_index;
        rem_q   <= count;
      end

      if (load) begin
        out_data  <= reg_data;
        out_index <= idx_q;
        out_last  <= (rem_q == REM_ONE);
        out_valid <= 1'b1;
        // Explicit wrap keeps non-power-of-two WIDTH correct.
        idx_q     <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
        rem_q     <= rem_q - REM_ONE;
      end else begin
        if (out_ready) out_valid <= 1'b0;
        if (finish) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mat_reg_streamer.sv
// Bench for mat_reg_streamer: table of directed requests, hand-written corner sequences,
// and randomized requests scored against a register/stream reference model.
// Register is modelled combinationally from mem[r][c].

module tb_mat_reg_streamer;
  import mat_reg_pkg::*;

  localparam int WIDTH  = 4;
  localparam int AW     = 2;
  localparam int DW     = 16;
  localparam int VW     = WIDTH * DW;
  localparam int BUDGET = 40;

  localparam logic [VW-1:0] ROW0  = {16'd3,  16'd2,  16'd1,  16'd0};
  localparam logic [VW-1:0] ROW2  = {16'd23, 16'd22, 16'd21, 16'd20};
  localparam logic [VW-1:0] COL3  = {16'd33, 16'd23, 16'd13, 16'd3};
  localparam logic [VW-1:0] DIAG1 = {16'd32, 16'd23, 16'd10, 16'd1};

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     start;
  MatDataReadOp_t           mode;
  logic [AW-1:0]            start_index;
  logic [AW:0]              count;
  MatDataReadOp_t           read_op;
  logic [AW-1:0]            read_param1;
  logic [AW-1:0]            read_param2;
  logic [WIDTH-1:0][DW-1:0] reg_data;
  logic [WIDTH-1:0][DW-1:0] out_data;
  logic [AW-1:0]            out_index;
  logic                     out_last;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;
  logic                     done;
  logic                     start_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [WIDTH][WIDTH];

  typedef struct {
    int            idx;
    logic [VW-1:0] dat;
    logic          last;
  } xfer_t;

  typedef struct {
    MatDataReadOp_t m;
    int             si;
    int             cnt;
    logic [15:0]    rdy;
    bit             noise;
    int             exp_done;
    logic [VW-1:0]  first;
  } vec_t;

  vec_t tbl [6];

  mat_reg_streamer #(.WIDTH(WIDTH), .WIDTH_ADDR_SIZE(AW), .DATA_W(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .start_index (start_index),
    .count       (count),
    .read_op     (read_op),
    .read_param1 (read_param1),
    .read_param2 (read_param2),
    .reg_data    (reg_data),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .start_err   (start_err)
  );

  always #5 clock = ~clock;

  // Matrix register read port: row, column or wrapped diagonal of mem.
  function automatic logic [VW-1:0] reg_read(input MatDataReadOp_t op, input int k);
    logic [WIDTH-1:0][DW-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (op)
        ROW:     v[i] = mem[k][i];
        COL:     v[i] = mem[i][k];
        DIAG:    v[i] = mem[i][(k - i + WIDTH) % WIDTH];
        default: v[i] = '0;
      endcase
    end
    return v;
  endfunction

  always_comb reg_data = reg_read(read_op, int'(read_param1));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one request (start in cycle 0) and score every transfer until done.
  // exp_done < 0: only require that done arrives. same=1: cycle 0 is the current cycle.
  task automatic run_req(input MatDataReadOp_t m, input int si, input int cnt,
                         input logic [15:0] rdy, input bit noise, input int exp_done,
                         input bit chk_first, input logic [VW-1:0] first, input bit same);
    xfer_t         q[$];
    xfer_t         e;
    int            done_cyc = -1;
    bit            first_seen = 0;
    bit            prev_stall = 0;
    logic [VW-1:0] pd = '0;
    logic [AW-1:0] pi = '0;
    logic [AW-1:0] pp = '0;
    logic          pl = 1'b0;

    for (int j = 0; j < cnt; j++) begin
      e.idx  = (si + j) % WIDTH;
      e.dat  = reg_read(m, e.idx);
      e.last = (j == cnt - 1);
      q.push_back(e);
    end

    for (int c = 0; c < BUDGET; c++) begin
      if (!(c == 0 && same)) begin
        @(posedge clock);
        #1;
      end
      if (c == 0) begin
        start       = 1'b1;
        mode        = m;
        start_index = AW'(si);
        count       = (AW+1)'(cnt);
      end else if (noise && c < exp_done) begin
        start       = 1'b1;
        mode        = COL;
        start_index = 2'd2;
        count       = 3'd5;
      end else begin
        start = 1'b0;
      end
      out_ready = (c < 16) ? rdy[c] : 1'b1;
      if (c == 0 && same) continue;
      @(negedge clock);

      if (c == 1) chk("busy_c1", busy, 1);
      if (out_valid) chk("rp1_track", read_param1, (int'(out_index) + 1) % WIDTH);
      if (out_valid && prev_stall) begin
        chk("stall_data", out_data, pd);
        chk("stall_index", out_index, pi);
        chk("stall_last", out_last, pl);
        chk("stall_rp1", read_param1, pp);
      end
      if (out_valid && out_ready) begin
        chk("xfer_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("xfer_data", out_data, e.dat);
          chk("xfer_index", out_index, e.idx);
          chk("xfer_last", out_last, e.last);
          if (chk_first && !first_seen) chk("first_vec", out_data, first);
          first_seen = 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data;
      pi = out_index;
      pl = out_last;
      pp = read_param1;
      if (done) begin
        done_cyc = c;
        chk("busy_at_done", busy, 0);
        break;
      end
    end
    start = 1'b0;

    if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
    else               chk("done_seen", done_cyc >= 0, 1);
    chk("all_delivered", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int   xfers;
    bit   saw_done;

    for (int r = 0; r < WIDTH; r++)
      for (int c = 0; c < WIDTH; c++)
        mem[r][c] = DW'(10 * r + c);

    tbl[0] = '{ROW,  0, 4, 16'hFFFF, 1'b0, 6, ROW0};
    tbl[1] = '{COL,  3, 2, 16'hFFFF, 1'b0, 4, COL3};
    tbl[2] = '{ROW,  0, 3, 16'hFFE3, 1'b0, 8, ROW0};
    tbl[3] = '{DIAG, 1, 1, 16'hFFFF, 1'b0, 3, DIAG1};
    tbl[4] = '{ROW,  0, 0, 16'hFFFF, 1'b0, 2, '0};
    tbl[5] = '{ROW,  0, 2, 16'hFFFF, 1'b1, 4, ROW0};

    reset       = 1'b1;
    start       = 1'b0;
    mode        = DISABLE;
    start_index = '0;
    count       = '0;
    out_ready   = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start_err", start_err, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_read_op", read_op, DISABLE);
    chk("rst_read_param2", read_param2, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    for (int t = 0; t < 6; t++) begin
      run_req(tbl[t].m, tbl[t].si, tbl[t].cnt, tbl[t].rdy, tbl[t].noise,
              tbl[t].exp_done, tbl[t].cnt != 0, tbl[t].first, 1'b0);
      // New start is accepted in the same cycle that done pulses.
      if (t == 4) run_req(ROW, 2, 1, 16'hFFFF, 1'b0, 3, 1'b1, ROW2, 1'b1);
    end

    // Illegal mode: one-cycle start_err, never busy.
    @(posedge clock);
    #1;
    start = 1'b1;
    mode  = SCALAR;
    count = 3'd2;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    chk("serr_pulse", start_err, 1);
    chk("serr_busy", busy, 0);
    @(posedge clock);
    @(negedge clock);
    chk("serr_clear", start_err, 0);
    chk("serr_busy2", busy, 0);

    // Mid-stream reset after two transfers.
    @(posedge clock);
    #1;
    start       = 1'b1;
    mode        = ROW;
    start_index = '0;
    count       = 3'd4;
    out_ready   = 1'b1;
    xfers       = 0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      if (c == 4) reset = 1'b1;
      @(negedge clock);
      if (c <= 3 && out_valid && out_ready) xfers++;
    end
    chk("rst_mid_xfers", xfers, 2);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_read_op", read_op, DISABLE);
    chk("rst_mid_done", done, 0);
    saw_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (done) saw_done = 1;
    end
    chk("rst_mid_no_done", saw_done, 0);
    run_req(ROW, 0, 4, 16'hFFFF, 1'b0, 6, 1'b1, ROW0, 1'b0);

    // Randomized requests against the reference model.
    for (int n = 0; n < 25; n++) begin
      MatDataReadOp_t rm;
      for (int r = 0; r < WIDTH; r++)
        for (int c = 0; c < WIDTH; c++)
          mem[r][c] = DW'($urandom);
      rm = MatDataReadOp_t'(3'($urandom_range(1, 3)));
      run_req(rm, $urandom_range(0, WIDTH - 1), $urandom_range(0, 2 * WIDTH - 1),
              16'($urandom), 1'b0, -1, 1'b0, '0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
